// File: rtl/fuzz_stim_pkg.sv
// Shared definitions for the fuzzer stimulus blocks: serializer state encoding
// and default word/gap widths.
package fuzz_stim_pkg;

    localparam int WORD_W_DEF = 32;
    localparam int GAP_W_DEF  = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

endpackage

// File: rtl/down_counter.sv
// Loadable down counter with zero detect; load wins over decrement and the
// count never wraps below zero.
module down_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count_r;

    // Count register: load, saturating decrement, or hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {W{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (dec && (count_r != {W{1'b0}})) begin
            count_r <= count_r - W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign zero = (count_r == {W{1'b0}});

endmodule

// File: rtl/strobe_serializer.sv
// Serializes handshaked parallel words onto a strobed single-bit stream for the
// capture register, with optional stb-low gap cycles between bits.
module strobe_serializer
    import fuzz_stim_pkg::*;
#(
    parameter int WORD_W    = WORD_W_DEF,
    parameter int GAP_W     = GAP_W_DEF,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic [GAP_W-1:0]  in_gap,
    output logic              stb,
    output logic              di,
    output logic              busy,
    output logic              done
);

    localparam int BIT_W = $clog2(WORD_W);
    localparam logic [1:0] IDLE  = ST_IDLE;
    localparam logic [1:0] SHIFT = ST_SHIFT;
    localparam logic [1:0] GAP   = ST_GAP;

    logic [1:0]        state_r, state_s;
    logic [WORD_W-1:0] shift_r, shift_s;
    logic [GAP_W-1:0]  gap_reload_r;
    logic              ready_en_r;
    logic              stb_r, di_r, busy_r, done_r;
    logic              stb_s, di_s, busy_s, done_s;
    logic              accept_s;
    logic              bit_zero_s, bit_load_s, bit_dec_s;
    logic              gap_zero_s, gap_load_s, gap_dec_s;

    function automatic logic head_bit(input logic [WORD_W-1:0] w);
        return LSB_FIRST ? w[0] : w[WORD_W-1];
    endfunction

    function automatic logic [WORD_W-1:0] advance(input logic [WORD_W-1:0] w);
        return LSB_FIRST ? (w >> 1) : (w << 1);
    endfunction

    // ready_en_r keeps in_ready low until the first edge after reset release
    assign in_ready = ready_en_r & (state_r == IDLE);
    assign accept_s = in_valid & in_ready;

    // Next-state, shift and counter control
    always_comb begin
        state_s    = state_r;
        shift_s    = shift_r;
        done_s     = 1'b0;
        bit_load_s = 1'b0;
        bit_dec_s  = 1'b0;
        gap_load_s = 1'b0;
        gap_dec_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s    = SHIFT;
                    shift_s    = in_data;
                    bit_load_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (bit_zero_s) begin
                    state_s = IDLE;
                    done_s  = 1'b1;
                end else begin
                    shift_s   = advance(shift_r);
                    bit_dec_s = 1'b1;
                    if (gap_reload_r == {GAP_W{1'b0}}) begin
                        state_s = SHIFT;
                    end else begin
                        state_s    = GAP;
                        gap_load_s = 1'b1;
                    end
                end
            end
            GAP: begin
                if (gap_zero_s) begin
                    state_s = SHIFT;
                end else begin
                    state_s   = GAP;
                    gap_dec_s = 1'b1;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Outputs are computed from the next state so they can be registered
    assign stb_s  = (state_s == SHIFT);
    assign busy_s = (state_s != IDLE);
    assign di_s   = (state_s == SHIFT) ? head_bit(shift_s) : di_r;

    // State, data path and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            shift_r      <= {WORD_W{1'b0}};
            gap_reload_r <= {GAP_W{1'b0}};
            ready_en_r   <= 1'b0;
            stb_r        <= 1'b0;
            di_r         <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            shift_r      <= shift_s;
            gap_reload_r <= accept_s ? in_gap : gap_reload_r;
            ready_en_r   <= 1'b1;
            stb_r        <= stb_s;
            di_r         <= di_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
        end
    end

    down_counter #(.W(BIT_W)) u_bit_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (bit_load_s),
        .load_val (BIT_W'(WORD_W - 1)),
        .dec      (bit_dec_s),
        .zero     (bit_zero_s)
    );

    down_counter #(.W(GAP_W)) u_gap_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (gap_load_s),
        .load_val (gap_reload_r - GAP_W'(1)),
        .dec      (gap_dec_s),
        .zero     (gap_zero_s)
    );

    assign stb  = stb_r;
    assign di   = di_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: tb/tb_strobe_serializer.sv
// Self-checking bench: a 32-bit LSB-first instance checked cycle by cycle against
// a queue-based stream model, plus an 8-bit MSB-first instance with maximum gap.
module tb_strobe_serializer;

    localparam int W  = 32;
    localparam int GW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          a_valid, a_ready, a_stb, a_di, a_busy, a_done;
    logic [W-1:0]  a_data;
    logic [GW-1:0] a_gap;
    logic          b_valid, b_ready, b_stb, b_di, b_busy, b_done;
    logic [7:0]    b_data;
    logic [GW-1:0] b_gap;

    int checks = 0;
    int errors = 0;

    strobe_serializer #(.WORD_W(W), .GAP_W(GW), .LSB_FIRST(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_valid), .in_ready(a_ready),
        .in_data(a_data), .in_gap(a_gap), .stb(a_stb), .di(a_di),
        .busy(a_busy), .done(a_done)
    );

    strobe_serializer #(.WORD_W(8), .GAP_W(GW), .LSB_FIRST(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_valid), .in_ready(b_ready),
        .in_data(b_data), .in_gap(b_gap), .stb(b_stb), .di(b_di),
        .busy(b_busy), .done(b_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Expected per-cycle behaviour of dut_a, built from each accepted word
    typedef struct packed {logic stb; logic di; logic busy; logic done;} cyc_t;
    cyc_t exp_q[$];
    logic released;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) released <= 1'b0;
        else        released <= 1'b1;
    end

    task automatic push_word(input logic [W-1:0] d, input int g);
        for (int i = 0; i < W; i++) begin
            exp_q.push_back({1'b1, d[i], 1'b1, 1'b0});
            if (i != W - 1)
                for (int k = 0; k < g; k++) exp_q.push_back({1'b0, d[i], 1'b1, 1'b0});
        end
        exp_q.push_back({1'b0, 1'b0, 1'b0, 1'b1});
    endtask

    always @(negedge clk) begin
        cyc_t e;
        logic exp_ready;
        if (!rst_n) begin
            exp_q.delete();
            chk("rst_stb", a_stb, 1'b0);
            chk("rst_busy", a_busy, 1'b0);
            chk("rst_done", a_done, 1'b0);
            chk("rst_ready", a_ready, 1'b0);
        end else begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 4'b0000;
            exp_ready = released && !e.busy;
            chk("stb", a_stb, e.stb);
            chk("busy", a_busy, e.busy);
            chk("done", a_done, e.done);
            chk("in_ready", a_ready, exp_ready);
            if (e.busy) chk("di", a_di, e.di);
            if (a_valid && exp_ready) push_word(a_data, int'(a_gap));
        end
    end

    typedef struct {
        logic [W-1:0]  data;
        logic [GW-1:0] gap;
        int            span;
        int            pulses;
    } vec_t;
    vec_t tbl[6];

    task automatic send_a(input logic [W-1:0] d, input logic [GW-1:0] g);
        int n = 0;
        while (!a_ready && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("send_timeout", n < 2000, 1'b1);
        a_valid = 1'b1;
        a_data  = d;
        a_gap   = g;
        @(posedge clk); #1;
        a_valid = 1'b0;
    endtask

    // Sends one word, scrambles the inputs while it is in flight, and checks the totals
    task automatic run_word(input vec_t v);
        logic [W-1:0] cap = '0;
        int span = 0, pulses = 0, n = 0;
        send_a(v.data, v.gap);
        while (!a_done && n < 2000) begin
            if (a_busy) span++;
            if (a_stb) begin
                if (pulses < W) cap[pulses] = a_di;
                pulses++;
            end
            chk("ready_while_busy", a_ready, 1'b0);
            a_data = $urandom;
            a_gap  = GW'($urandom);
            @(posedge clk); #1;
            n++;
        end
        chk("done_timeout", n < 2000, 1'b1);
        chk("done_cycle", n, v.span);
        chk("span", span, v.span);
        chk("pulses", pulses, v.pulses);
        chk("capture", cap, v.data);
        chk("ready_at_done", a_ready, 1'b1);
    endtask

    initial begin : main
        int n, span, pulses, low_run, g;
        logic last_di;
        logic [7:0] bdata;
        vec_t rv;

        tbl[0] = '{32'hA5A5_0F0F, 4'd0,  32,  32};
        tbl[1] = '{32'h0000_0003, 4'd2,  94,  32};
        tbl[2] = '{32'hFFFF_FFFF, 4'd0,  32,  32};
        tbl[3] = '{32'h0000_0000, 4'd0,  32,  32};
        tbl[4] = '{32'h1234_5678, 4'd1,  63,  32};
        tbl[5] = '{32'hDEAD_BEEF, 4'd15, 497, 32};

        rst_n = 1'b0;
        a_valid = 1'b0; a_data = '0; a_gap = '0;
        b_valid = 1'b0; b_data = '0; b_gap = '0;
        #2;
        chk("init_stb", a_stb, 1'b0);
        chk("init_di", a_di, 1'b0);
        chk("init_busy", a_busy, 1'b0);
        chk("init_done", a_done, 1'b0);
        chk("init_ready", a_ready, 1'b0);
        chk("init_b_ready", b_ready, 1'b0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_release", a_ready, 1'b1);

        // Directed words back to back: each accept lands in the previous done cycle
        for (int i = 0; i < 6; i++) run_word(tbl[i]);

        for (int i = 0; i < 6; i++) begin
            g = int'($urandom_range(0, 3));
            rv.data = $urandom;
            rv.gap = GW'(g);
            rv.span = W + (W - 1) * g;
            rv.pulses = W;
            run_word(rv);
        end

        // Reset in the middle of a word
        send_a(32'hFFFF_0000, 4'd0);
        pulses = 0; n = 0;
        while (n < 200) begin
            if (a_stb) pulses++;
            if (pulses == 10) break;
            @(posedge clk); #1;
            n++;
        end
        chk("tenth_pulse_seen", pulses, 10);
        #2 rst_n = 1'b0;
        #1;
        chk("async_stb", a_stb, 1'b0);
        chk("async_busy", a_busy, 1'b0);
        chk("async_ready", a_ready, 1'b0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        rv.data = 32'h1234_5678; rv.gap = 4'd0; rv.span = 32; rv.pulses = 32;
        run_word(rv);

        // 8-bit MSB-first word with the widest gap
        bdata = 8'h81;
        n = 0;
        while (!b_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("b_send_timeout", n < 100, 1'b1);
        b_valid = 1'b1; b_data = bdata; b_gap = 4'd15;
        @(posedge clk); #1;
        b_valid = 1'b0;
        span = 0; pulses = 0; low_run = 0; last_di = 1'b0; n = 0;
        while (!b_done && n < 1000) begin
            if (b_busy) span++;
            if (b_stb) begin
                if (pulses > 0) chk("b_gap_len", low_run, 15);
                if (pulses < 8) chk("b_di", b_di, bdata[7 - pulses]);
                last_di = b_di;
                pulses++;
                low_run = 0;
            end else if (b_busy) begin
                low_run++;
                chk("b_di_hold", b_di, last_di);
            end
            b_data = 8'($urandom);
            b_gap = GW'($urandom);
            @(posedge clk); #1;
            n++;
        end
        chk("b_done_timeout", n < 1000, 1'b1);
        chk("b_span", span, 113);
        chk("b_pulses", pulses, 8);
        chk("b_ready_at_done", b_ready, 1'b1);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/strobe_serializer.md
Name: strobe_serializer

Overview:
- Upstream stimulus stage for the strobed capture register used in the part/bitstream fuzzers.
- Accepts parallel words over a valid/ready handshake and serializes each word onto a single data bit `di`, qualified by a strobe `stb`.
- Optional idle gap cycles between bits exercise the capture register's hold path while `stb` is low.
- Drives the capture register's `stb`/`di` inputs directly; no logic in between.

Parameters:
- WORD_W, 32: bits per input word; legal range ≥ 2.
- GAP_W, 4: width of the per-word gap count.
- LSB_FIRST, 1: 1 = bit 0 shifted first; 0 = bit WORD_W-1 shifted first.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset; deassertion is synchronous to clk externally.
- in_valid  in  1  in_data/in_gap are valid.
- in_ready  out  1  block can accept a word this cycle.
- in_data  in  WORD_W  word to serialize.
- in_gap  in  GAP_W  stb-low cycles inserted after each bit except the last.
- stb  out  1  strobe to the capture stage; high exactly one cycle per bit.
- di  out  1  serial data bit; meaningful when stb=1.
- busy  out  1  high while a word is in flight (SHIFT or GAP).
- done  out  1  one-cycle pulse after the last bit of a word.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; stb=0, di=0, busy=0, done=0. in_ready=0 while rst_n=0 and 1 from the first clk edge after release. Shift register, bit counter and gap counter clear to 0.
- Accept: in_valid & in_ready at an edge. That edge latches in_data into the shift register and in_gap into gap_reload, and loads bit_cnt=WORD_W-1. The state then becomes SHIFT.
- in_ready = (state==IDLE). Combinational from the state register only; it never depends on in_valid.
- State machine:
  - IDLE → SHIFT on accept.
  - SHIFT: registered outputs are stb=1 and di = current head bit (bit 0 if LSB_FIRST, else bit WORD_W-1). busy=1.
    - If bit_cnt==0: → IDLE, and done=1 for exactly that next cycle.
    - Else if gap_reload==0: stay in SHIFT, shift by one, bit_cnt-1.
    - Else: → GAP, gap_cnt=gap_reload-1, shift by one, bit_cnt-1.
  - GAP: stb=0, di holds the last driven value, busy=1.
    - gap_cnt==0 → SHIFT.
    - Otherwise gap_cnt-1.
- Latency:
  - First stb rises in the cycle after the accept edge.
  - With gap=0, the word occupies exactly WORD_W consecutive stb-high cycles.
  - With gap=g, total span is WORD_W + (WORD_W-1)*g cycles, with no gap after the final bit.
- Back-to-back words: done and in_ready are both high in the first IDLE cycle, so a word can be accepted there. Minimum word period is therefore WORD_W+1 cycles. stb is guaranteed low for ≥1 cycle between words.
- in_data and in_gap are ignored unless an accept occurs. Changing them mid-word has no effect.
- Reset mid-word: the word is abandoned. stb and busy drop immediately (asynchronously). done is not pulsed.
- Counter widths:
  - bit_cnt is $clog2(WORD_W) bits.
  - gap_cnt is GAP_W bits.
  - Decrements never wrap because each branch checks for zero first.

Decomposition:
- Shared package `fuzz_stim_pkg`:
  - state enum {IDLE, SHIFT, GAP} as a 2-bit typedef.
  - localparam defaults for WORD_W and GAP_W.
- One sub-module is natural: `down_counter`, a loadable, zero-detecting down counter parameterized by width. Instantiate it twice, for bit_cnt and gap_cnt.
- Shift register and FSM stay in the top.

Test Plan:
- Reset release, then in_valid=1, in_data=32'hA5A5_0F0F, in_gap=0, LSB_FIRST=1:
  - stb high for exactly 32 consecutive cycles starting the cycle after accept.
  - The di sequence matches bits 0..31.
  - done pulses once on cycle 33; in_ready=1 that same cycle.
- in_data=32'h0000_0003, in_gap=2:
  - stb pattern is 1,0,0 repeated, then a final 1; total 32+31*2 = 94 cycles.
  - di holds during the gap cycles.
  - The captured bits (sampled when stb=1) equal the word.
- in_valid held high with two queued words (32'hFFFF_FFFF, then 32'h0):
  - The second accept happens in the done cycle.
  - Exactly one stb-low cycle separates the words; 64 stb pulses total.
- Assert rst_n=0 at the 10th stb pulse:
  - stb, busy and in_ready go low without waiting for a clock edge.
  - No done pulse.
  - After release, a fresh word 32'h1234_5678 serializes correctly from bit 0.
- LSB_FIRST=0, WORD_W=8, in_data=8'b1000_0001, in_gap=15:
  - First and last di values are 1, middle values 0.
  - 15 stb-low cycles between each pair of bits; total 8+7*15 = 113 cycles.
- in_data and in_gap toggled randomly while busy=1:
  - Output stream is unchanged.
  - in_ready stays 0 until the done cycle.
